slc3_mem_bridge: RTL and testbench
==================================

// Module: slc3_mem_bridge
// PURPOSE
//  Memory-side stage directly downstream of the SLC-3 core. Consumes the core's
//  mem_addr/mem_wdata/mem_mem_ena/mem_wr_ena and returns mem_rdata.
//  Arbitrates one access at a time to a synchronous block RAM with fixed read
//  pipeline latency, and decodes one memory-mapped I/O word (switches in, hex out).
//  Signals completion of each access with a one-cycle mem_ready pulse.
// PARAMETERS
//  RAM_AW      16       block RAM address width; RAM spans 0 .. 2^RAM_AW-1
//  RD_LATENCY  2        RAM read pipeline depth in cycles (legal 1..3)
//  IO_ADDR     16'hFFFF memory-mapped I/O word address; overrides RAM decode
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  reset        in   1       asynchronous, active-low reset
//  mem_mem_ena  in   1       core access request (level)
//  mem_wr_ena   in   1       1 = write, 0 = read; sampled with request
//  mem_addr     in   16      core address (MAR)
//  mem_wdata    in   16      core write data (MDR)
//  mem_rdata    out  16      registered read data to core MDR mux
//  mem_ready    out  1       one-cycle access-complete pulse
//  ram_en       out  1       RAM enable
//  ram_we       out  1       RAM write enable
//  ram_addr     out  RAM_AW  RAM address
//  ram_wdata    out  16      RAM write data
//  ram_rdata    in   16      RAM read data, valid RD_LATENCY cycles after ram_en
//  sw_i         in   16      board switches, asynchronous
//  hex_o        out  16      hex display register
// BEHAVIOUR
//  Reset (reset=0, async):
//   - All outputs 0. FSM enters IDLE. Latched request, latency counter and switch
//     synchroniser cleared.
//   - Applies mid-access. An in-flight RAM write is dropped if reset lands before
//     its ram_we cycle.
//  sw_i passes through a 2-flop synchroniser (sw_sync) before any use.
//  FSM states: IDLE, ISSUE, RD_WAIT, DONE, HOLD.
//  IDLE: when mem_mem_ena=1 in cycle T, latch addr/wdata/wr at end of T. Then:
//   - IO_ADDR read: mem_rdata<=sw_sync; go to DONE. mem_ready=1 in T+1.
//   - IO_ADDR write: hex_o<=mem_wdata; go to DONE. mem_ready=1 in T+1.
//   - RAM address (addr < 2^RAM_AW): go to ISSUE.
//   - Unmapped (addr >= 2^RAM_AW and not IO_ADDR): read gives mem_rdata<=0; write
//     is dropped; go to DONE.
//  ISSUE (cycle T+1): ram_en=1, ram_addr=latched addr[RAM_AW-1:0].
//   - Write: ram_we=1, ram_wdata=latched data, mem_ready=1 in this cycle; go to HOLD.
//   - Read: ram_we=0; load counter with RD_LATENCY-1; go to RD_WAIT.
//  RD_WAIT: counter decrements each cycle. At counter==0 (cycle T+1+RD_LATENCY):
//   mem_rdata<=ram_rdata; go to DONE.
//  DONE: mem_ready=1 for exactly this cycle; go to HOLD.
//  HOLD: the core holds mem_mem_ena across several control states, so the bridge
//   waits here until mem_mem_ena=0, then goes to IDLE. No access repeats.
//  Latency, request at T to mem_ready: IO/unmapped = 1; RAM write = 1 (ISSUE cycle);
//   RAM read = RD_LATENCY+2 (4 at default).
//  mem_rdata changes only on read completion and holds between accesses.
//  hex_o changes only on an IO_ADDR write.
//  ram_en/ram_we are high only in ISSUE, never more than one cycle per access.
//  Address, data and wr changes after acceptance are ignored until IDLE.
//  mem_mem_ena dropping mid-access does not abort it. Completion still pulses
//   mem_ready, then HOLD exits on the next cycle.
//  Exactly one access is outstanding at any time. No queuing.
// TESTING
//  1. Reset low with RAM read in RD_WAIT -> outputs 0 at once, FSM IDLE, no mem_ready.
//  2. Write 16'h1234 to 16'h0010 -> ram_en=ram_we=1 one cycle at T+1, mem_ready T+1.
//     Then read 16'h0010 -> mem_ready at T+4, mem_rdata=16'h1234.
//  3. sw_i=16'hBEEF, read 16'hFFFF -> mem_rdata=16'hBEEF at T+1, ram_en never asserted.
//  4. Write 16'h00A5 to 16'hFFFF -> hex_o=16'h00A5 from T+1, RAM untouched.
//  5. Hold mem_mem_ena high 6 cycles on a write -> exactly one ram_we pulse and one
//     mem_ready pulse. Drop, re-raise -> second access accepted.
//  6. RAM_AW=12, read 16'h2000 -> mem_rdata=16'h0000, mem_ready T+1.
//     Write there -> no ram_we.

Source files
------------

// File: rtl/slc3_mem_bridge_if.sv
// Core-side memory bus and block-RAM port of the SLC-3 memory bridge.
// Latency: none, wires only.
// Backpressure: none; completion is signalled by the bridge with mem_ready.
interface slc3_mem_bridge_if #(
    parameter int RAM_AW = 16
);
    // core side
    logic              mem_mem_ena;
    logic              mem_wr_ena;
    logic [15:0]       mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_ready;
    // block RAM side
    logic              ram_en;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [15:0]       ram_wdata;
    logic [15:0]       ram_rdata;

    // environment: the core plus the RAM macro
    modport master (
        output mem_mem_ena, mem_wr_ena, mem_addr, mem_wdata, ram_rdata,
        input  mem_rdata, mem_ready, ram_en, ram_we, ram_addr, ram_wdata
    );

    // the bridge itself
    modport slave (
        input  mem_mem_ena, mem_wr_ena, mem_addr, mem_wdata, ram_rdata,
        output mem_rdata, mem_ready, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/slc3_mem_bridge.sv
// Single-outstanding memory bridge: block RAM, one memory-mapped I/O word (switches/hex).
// Latency request->mem_ready: I/O, unmapped and RAM write 1 cycle; RAM read RD_LATENCY+2.
// Backpressure: a request is taken only in IDLE; the core must hold mem_mem_ena until mem_ready.
module slc3_mem_bridge #(
    parameter int          RAM_AW     = 16,
    parameter int          RD_LATENCY = 2,
    parameter logic [15:0] IO_ADDR    = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    slc3_mem_bridge_if.slave     bus,
    input  logic [15:0]          sw_i,
    output logic [15:0]          hex_o
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] DONE    = 3'd3;
    localparam logic [2:0] HOLD    = 3'd4;

    logic [2:0]        state;
    logic [RAM_AW-1:0] lat_addr;
    logic [15:0]       lat_wdata;
    logic              lat_wr;
    logic [1:0]        cnt;
    logic [15:0]       rdata_q;
    logic [15:0]       hex_q;
    logic [15:0]       sw_meta;
    logic [15:0]       sw_sync;

    logic is_io;
    logic is_ram;
    logic in_issue;

    // Decode is done on the live address in IDLE; the I/O word wins over RAM.
    assign is_io    = (bus.mem_addr == IO_ADDR);
    assign is_ram   = !is_io && (32'(bus.mem_addr) < (32'd1 << RAM_AW));
    assign in_issue = (state == ISSUE);

    // RAM strobes exist only in ISSUE, so each access touches the RAM at most once.
    assign bus.ram_en    = in_issue;
    assign bus.ram_we    = in_issue && lat_wr;
    assign bus.ram_addr  = in_issue ? lat_addr : '0;
    assign bus.ram_wdata = (in_issue && lat_wr) ? lat_wdata : 16'h0000;

    // A RAM write completes in its ISSUE cycle; everything else completes in DONE.
    assign bus.mem_ready = (state == DONE) || (in_issue && lat_wr);
    assign bus.mem_rdata = rdata_q;
    assign hex_o         = hex_q;

    // Two-flop synchroniser for the asynchronous board switches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta <= 16'h0000;
            sw_sync <= 16'h0000;
        end else begin
            sw_meta <= sw_i;
            sw_sync <= sw_meta;
        end
    end

    // Access FSM: accept, decode, issue to RAM, wait out read latency, complete, hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_wdata <= 16'h0000;
            lat_wr    <= 1'b0;
            cnt       <= 2'd0;
            rdata_q   <= 16'h0000;
            hex_q     <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mem_mem_ena) begin
                        lat_addr  <= bus.mem_addr[RAM_AW-1:0];
                        lat_wdata <= bus.mem_wdata;
                        lat_wr    <= bus.mem_wr_ena;
                        if (is_io) begin
                            if (bus.mem_wr_ena) begin
                                hex_q <= bus.mem_wdata;
                            end else begin
                                rdata_q <= sw_sync;
                            end
                            state <= DONE;
                        end else if (is_ram) begin
                            state <= ISSUE;
                        end else begin
                            // unmapped: reads return zero, writes vanish
                            if (!bus.mem_wr_ena) begin
                                rdata_q <= 16'h0000;
                            end
                            state <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (lat_wr) begin
                        state <= HOLD;
                    end else begin
                        cnt   <= 2'(RD_LATENCY - 1);
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (cnt == 2'd0) begin
                        rdata_q <= bus.ram_rdata;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                DONE: begin
                    state <= HOLD;
                end
                HOLD: begin
                    // the core keeps mem_mem_ena up across several control states
                    if (!bus.mem_mem_ena) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slc3_mem_bridge.sv
// Self-checking bench for slc3_mem_bridge: directed scenarios plus a randomized run
// against a transaction-level reference model (latency rules, memory image, hex, rdata).
// Two bridges are instantiated: RAM_AW=16 and RAM_AW=12 (unmapped region).
module tb_slc3_mem_bridge;

    localparam int RDL = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sw;
    logic [15:0] hex16;
    logic [15:0] hex12;

    int checks = 0;
    int errors = 0;

    int en_c[2];
    int we_c[2];
    int rdy_c[2];

    always #5 clk = ~clk;

    slc3_mem_bridge_if #(.RAM_AW(16)) b16();
    slc3_mem_bridge_if #(.RAM_AW(12)) b12();

    slc3_mem_bridge #(.RAM_AW(16), .RD_LATENCY(RDL), .IO_ADDR(16'hFFFF)) dut (
        .clk(clk), .reset(rst_n), .bus(b16), .sw_i(sw), .hex_o(hex16)
    );

    slc3_mem_bridge #(.RAM_AW(12), .RD_LATENCY(RDL), .IO_ADDR(16'hFFFF)) dut12 (
        .clk(clk), .reset(rst_n), .bus(b12), .sw_i(sw), .hex_o(hex12)
    );

    // Block RAM models with an RDL-deep read pipeline.
    logic [15:0] ram16 [0:65535];
    logic [15:0] ram12 [0:4095];
    logic [15:0] p16 [0:2];
    logic [15:0] p12 [0:2];

    always @(posedge clk) begin
        if (b16.ram_en && b16.ram_we) ram16[b16.ram_addr] <= b16.ram_wdata;
        p16[0] <= ram16[b16.ram_addr];
        p16[1] <= p16[0];
        p16[2] <= p16[1];
        if (b12.ram_en && b12.ram_we) ram12[b12.ram_addr] <= b12.ram_wdata;
        p12[0] <= ram12[b12.ram_addr];
        p12[1] <= p12[0];
        p12[2] <= p12[1];
    end

    assign b16.ram_rdata = p16[RDL-1];
    assign b12.ram_rdata = p12[RDL-1];

    // Pulse counters for RAM strobes and completions.
    always @(negedge clk) begin
        if (b16.ram_en)    en_c[0]++;
        if (b16.ram_we)    we_c[0]++;
        if (b16.mem_ready) rdy_c[0]++;
        if (b12.ram_en)    en_c[1]++;
        if (b12.ram_we)    we_c[1]++;
        if (b12.mem_ready) rdy_c[1]++;
    end

    // Reference latency from the address map.
    function automatic int exp_lat(input logic [15:0] a, input logic wr, input int aw);
        if (a == 16'hFFFF) return 1;
        if (int'(a) < (1 << aw)) return wr ? 1 : RDL + 2;
        return 1;
    endfunction

    task automatic drive(input int sel, input logic ena, input logic [15:0] a,
                         input logic wr, input logic [15:0] d);
        if (sel == 1) begin
            b12.mem_mem_ena = ena; b12.mem_addr = a; b12.mem_wr_ena = wr; b12.mem_wdata = d;
        end else begin
            b16.mem_mem_ena = ena; b16.mem_addr = a; b16.mem_wr_ena = wr; b16.mem_wdata = d;
        end
    endtask

    function automatic logic rdy_of(input int sel);
        return (sel == 1) ? b12.mem_ready : b16.mem_ready;
    endfunction

    // One complete access: raise request, wait (bounded) for mem_ready, drop, let HOLD exit.
    task automatic acc(input int sel, input logic [15:0] a, input logic wr,
                       input logic [15:0] d, output int lat, output logic [15:0] rd);
        logic got;
        got = 1'b0;
        lat = 0;
        @(negedge clk);
        drive(sel, 1'b1, a, wr, d);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (rdy_of(sel)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) lat = -1;
        rd = (sel == 1) ? b12.mem_rdata : b16.mem_rdata;
        drive(sel, 1'b0, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int lat;
        logic [15:0] rd;
        int r0;
        rst_n = 1'b0;
        sw = 16'h0000;
        drive(0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        drive(1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        repeat (3) @(negedge clk);
        checks++; if ({b16.mem_rdata, hex16} !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {b16.mem_rdata, hex16}); end
        checks++; if ({b16.mem_ready, b16.ram_en, b16.ram_we} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {b16.mem_ready, b16.ram_en, b16.ram_we}); end
        checks++; if ({b16.ram_addr, b16.ram_wdata} !== 32'h0) begin errors++; $display("FAIL reset_ram_bus: got %h expected 0", {b16.ram_addr, b16.ram_wdata}); end
        rst_n = 1'b1;
        @(negedge clk);
        // make outputs non-zero, then reset in the middle of a RAM read
        acc(0, 16'hFFFF, 1'b1, 16'h5A5A, lat, rd);
        acc(0, 16'h0003, 1'b1, 16'h1111, lat, rd);
        acc(0, 16'h0003, 1'b0, 16'h0000, lat, rd);
        checks++; if (rd !== 16'h1111) begin errors++; $display("FAIL reset_pre_read: got %h expected 1111", rd); end
        @(negedge clk);
        drive(0, 1'b1, 16'h0003, 1'b0, 16'h0000);
        @(negedge clk);
        checks++; if (b16.ram_en !== 1'b1) begin errors++; $display("FAIL reset_issue_seen: got %b expected 1", b16.ram_en); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({b16.mem_rdata, hex16} !== 32'h0) begin errors++; $display("FAIL reset_mid_data: got %h expected 0", {b16.mem_rdata, hex16}); end
        checks++; if ({b16.mem_ready, b16.ram_en, b16.ram_we} !== 3'b000) begin errors++; $display("FAIL reset_mid_strobes: got %b expected 000", {b16.mem_ready, b16.ram_en, b16.ram_we}); end
        r0 = rdy_c[0];
        repeat (5) @(negedge clk);
        checks++; if (rdy_c[0] !== r0) begin errors++; $display("FAIL reset_no_ready: got %0d pulses expected 0", rdy_c[0] - r0); end
        drive(0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        rst_n = 1'b1;
        sw = 16'h0F0F;
        repeat (3) @(negedge clk);
        acc(0, 16'hFFFF, 1'b0, 16'h0000, lat, rd);
        checks++; if (lat !== 1) begin errors++; $display("FAIL reset_idle_lat: got %0d expected 1", lat); end
        checks++; if (rd !== 16'h0F0F) begin errors++; $display("FAIL reset_idle_sw: got %h expected 0f0f", rd); end
    endtask

    task automatic test_write_read();
        int lat, e0, w0;
        logic [15:0] rd;
        e0 = en_c[0]; w0 = we_c[0];
        acc(0, 16'h0010, 1'b1, 16'h1234, lat, rd);
        checks++; if (lat !== 1) begin errors++; $display("FAIL wr_lat: got %0d expected 1", lat); end
        checks++; if ((en_c[0] - e0) !== 1 || (we_c[0] - w0) !== 1) begin errors++; $display("FAIL wr_strobes: got en %0d we %0d expected 1 1", en_c[0] - e0, we_c[0] - w0); end
        checks++; if (ram16[16'h0010] !== 16'h1234) begin errors++; $display("FAIL wr_ram_word: got %h expected 1234", ram16[16'h0010]); end
        e0 = en_c[0]; w0 = we_c[0];
        acc(0, 16'h0010, 1'b0, 16'h0000, lat, rd);
        checks++; if (lat !== RDL + 2) begin errors++; $display("FAIL rd_lat: got %0d expected %0d", lat, RDL + 2); end
        checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL rd_data: got %h expected 1234", rd); end
        checks++; if ((en_c[0] - e0) !== 1 || (we_c[0] - w0) !== 0) begin errors++; $display("FAIL rd_strobes: got en %0d we %0d expected 1 0", en_c[0] - e0, we_c[0] - w0); end
    endtask

    task automatic test_io();
        int lat, e0, w0;
        logic [15:0] rd;
        sw = 16'hBEEF;
        repeat (3) @(negedge clk);
        e0 = en_c[0]; w0 = we_c[0];
        acc(0, 16'hFFFF, 1'b0, 16'h0000, lat, rd);
        checks++; if (lat !== 1) begin errors++; $display("FAIL io_rd_lat: got %0d expected 1", lat); end
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL io_rd_data: got %h expected beef", rd); end
        acc(0, 16'hFFFF, 1'b1, 16'h00A5, lat, rd);
        checks++; if (lat !== 1) begin errors++; $display("FAIL io_wr_lat: got %0d expected 1", lat); end
        checks++; if (hex16 !== 16'h00A5) begin errors++; $display("FAIL io_hex: got %h expected 00a5", hex16); end
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL io_rdata_hold: got %h expected beef", rd); end
        checks++; if ((en_c[0] - e0) !== 0 || (we_c[0] - w0) !== 0) begin errors++; $display("FAIL io_ram_untouched: got en %0d we %0d expected 0 0", en_c[0] - e0, we_c[0] - w0); end
    endtask

    task automatic test_hold();
        int lat, w0, r0;
        logic [15:0] rd;
        w0 = we_c[0]; r0 = rdy_c[0];
        @(negedge clk);
        drive(0, 1'b1, 16'h0020, 1'b1, 16'h7777);
        @(negedge clk);
        // post-acceptance changes must be ignored
        drive(0, 1'b1, 16'h0021, 1'b1, 16'h9999);
        repeat (5) @(negedge clk);
        drive(0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        repeat (2) @(negedge clk);
        checks++; if ((we_c[0] - w0) !== 1 || (rdy_c[0] - r0) !== 1) begin errors++; $display("FAIL hold_single: got we %0d ready %0d expected 1 1", we_c[0] - w0, rdy_c[0] - r0); end
        checks++; if (ram16[16'h0020] !== 16'h7777) begin errors++; $display("FAIL hold_latched: got %h expected 7777", ram16[16'h0020]); end
        w0 = we_c[0];
        acc(0, 16'h0020, 1'b1, 16'h8888, lat, rd);
        checks++; if (lat !== 1 || (we_c[0] - w0) !== 1) begin errors++; $display("FAIL hold_second: got lat %0d we %0d expected 1 1", lat, we_c[0] - w0); end
        acc(0, 16'h0020, 1'b0, 16'h0000, lat, rd);
        checks++; if (rd !== 16'h8888) begin errors++; $display("FAIL hold_readback: got %h expected 8888", rd); end
    endtask

    task automatic test_drop();
        int lat;
        logic got;
        logic [15:0] rd;
        got = 1'b0;
        lat = 0;
        @(negedge clk);
        drive(0, 1'b1, 16'h0010, 1'b0, 16'h0000);
        @(negedge clk);
        lat = 1;
        got = b16.mem_ready;
        drive(0, 1'b0, 16'h0020, 1'b0, 16'h0000);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            got = b16.mem_ready;
        end
        checks++; if (lat !== RDL + 2) begin errors++; $display("FAIL drop_lat: got %0d expected %0d", lat, RDL + 2); end
        checks++; if (b16.mem_rdata !== 16'h1234) begin errors++; $display("FAIL drop_data: got %h expected 1234", b16.mem_rdata); end
        @(negedge clk);
        acc(0, 16'hFFFF, 1'b1, 16'h0C0C, lat, rd);
        checks++; if (lat !== 1 || hex16 !== 16'h0C0C) begin errors++; $display("FAIL drop_next: got lat %0d hex %h expected 1 0c0c", lat, hex16); end
    endtask

    task automatic test_unmapped();
        int lat, e0, w0;
        logic [15:0] rd;
        acc(1, 16'h0FFF, 1'b1, 16'hCAFE, lat, rd);
        checks++; if (lat !== 1 || ram12[12'hFFF] !== 16'hCAFE) begin errors++; $display("FAIL um_top_wr: got lat %0d word %h expected 1 cafe", lat, ram12[12'hFFF]); end
        acc(1, 16'h0FFF, 1'b0, 16'h0000, lat, rd);
        checks++; if (lat !== RDL + 2 || rd !== 16'hCAFE) begin errors++; $display("FAIL um_top_rd: got lat %0d data %h expected %0d cafe", lat, rd, RDL + 2); end
        e0 = en_c[1]; w0 = we_c[1];
        acc(1, 16'h2000, 1'b0, 16'h0000, lat, rd);
        checks++; if (lat !== 1 || rd !== 16'h0000) begin errors++; $display("FAIL um_rd: got lat %0d data %h expected 1 0000", lat, rd); end
        acc(1, 16'h2000, 1'b1, 16'h5555, lat, rd);
        checks++; if (lat !== 1) begin errors++; $display("FAIL um_wr_lat: got %0d expected 1", lat); end
        acc(1, 16'h1000, 1'b0, 16'h0000, lat, rd);
        checks++; if (lat !== 1 || rd !== 16'h0000) begin errors++; $display("FAIL um_boundary: got lat %0d data %h expected 1 0000", lat, rd); end
        checks++; if ((en_c[1] - e0) !== 0 || (we_c[1] - w0) !== 0) begin errors++; $display("FAIL um_no_ram: got en %0d we %0d expected 0 0", en_c[1] - e0, we_c[1] - w0); end
        checks++; if (ram12[12'h000] === 16'h5555) begin errors++; $display("FAIL um_alias: got 5555 at 000 expected untouched"); end
    endtask

    task automatic test_random();
        logic [15:0] ref_mem [16];
        logic [15:0] ref_hex;
        logic [15:0] ref_rd;
        logic [15:0] a, d, rd;
        logic wr;
        int lat, e0, w0, idx;
        ref_hex = hex16;
        ref_rd  = b16.mem_rdata;
        for (int i = 0; i < 16; i++) begin
            d = 16'($urandom);
            acc(0, 16'h0100 + 16'(i), 1'b1, d, lat, rd);
            ref_mem[i] = d;
        end
        for (int n = 0; n < 40; n++) begin
            sw = 16'($urandom);
            repeat (3) @(negedge clk);
            idx = int'($urandom_range(0, 15));
            a   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'h0100 + 16'(idx);
            wr  = 1'($urandom);
            d   = 16'($urandom);
            e0 = en_c[0]; w0 = we_c[0];
            acc(0, a, wr, d, lat, rd);
            if (a == 16'hFFFF) begin
                if (wr) ref_hex = d; else ref_rd = sw;
            end else begin
                if (wr) ref_mem[idx] = d; else ref_rd = ref_mem[idx];
            end
            checks++; if (lat !== exp_lat(a, wr, 16)) begin errors++; $display("FAIL rnd_lat[%0d]: got %0d expected %0d", n, lat, exp_lat(a, wr, 16)); end
            checks++; if (rd !== ref_rd) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", n, rd, ref_rd); end
            checks++; if (hex16 !== ref_hex) begin errors++; $display("FAIL rnd_hex[%0d]: got %h expected %h", n, hex16, ref_hex); end
            checks++; if ((en_c[0] - e0) !== ((a == 16'hFFFF) ? 0 : 1) || (we_c[0] - w0) !== ((a != 16'hFFFF && wr) ? 1 : 0)) begin
                errors++; $display("FAIL rnd_strobes[%0d]: got en %0d we %0d for addr %h wr %b", n, en_c[0] - e0, we_c[0] - w0, a, wr);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_io();
        test_hold();
        test_drop();
        test_unmapped();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
